lfsr_grant_ctrl: RTL and testbench
==================================

# lfsr_grant_ctrl

Round-robin scheduler that shares one 8-bit Galois LFSR random source among four requesters. A granted requester receives one pseudo-random word after the LFSR has advanced a programmable number of steps, so independent consumers draw non-overlapping sub-sequences. The block owns the LFSR state, supports run-time reseeding, and sits between the shared random-number datapath and its client blocks.

## Interface
- WIDTH, 8: LFSR and data width.
- TAPS, 8'hB8: Galois feedback mask (x^8+x^6+x^5+x^4+1, maximal length 255).
- SEED, 8'h01: reset value; also substituted for any zero seed.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  4  per-requester request; held high until its valid pulse.
- steps  in  4  LFSR advances per grant; 0 is treated as 1; sampled at grant.
- seed_ld  in  1  load seed_in into the LFSR; honoured in IDLE only.
- seed_in  in  WIDTH  new seed.
- gnt  out  4  one-hot grant, high during RUN and DONE.
- valid  out  1  one-cycle pulse, data is the granted word.
- data  out  WIDTH  last delivered word; held between pulses.
- busy  out  1  high in RUN and DONE.

## Operation
- LFSR step (right-shift Galois): if lfsr[0]=1, next = (lfsr>>1)^TAPS, else next = lfsr>>1. The LFSR advances only in RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE: seed_ld=1 loads seed_in (or SEED if seed_in=0) and stays in IDLE. seed_ld has priority over req in the same cycle. Otherwise, if req is non-zero, pick the first set bit searching from (last+1) mod 4 upward with wrap. Set gnt to one-hot(winner), cnt = (steps==0)?1:steps, last = winner, and go to RUN.
- RUN: advance the LFSR and decrement cnt each cycle. When cnt=1 (final advance), capture the advanced value into data, set valid, and go to DONE.
- DONE: valid=1 for exactly this cycle. Clear gnt and go to IDLE on the next edge.
- Dropping req during RUN/DONE does not abort the grant. The word is still delivered and the pointer is still updated.
- seed_ld and changes to steps during RUN/DONE are ignored.
- LFSR state is never zero. Only a seed_in of 0 could produce zero, and it is replaced by SEED.
- Reset values: lfsr=SEED, state=IDLE, gnt=0, valid=0, busy=0, data=0, last=3 (requester 0 has first priority).
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). Any in-flight grant is discarded with no valid pulse.

## Timing
- req sampled high in IDLE at edge k: gnt and busy rise after edge k.
- With S=max(steps,1), valid is high in the cycle after edge k+S, and data updates at that same edge.
- IDLE is re-entered after edge k+S+1, and the next grant can occur at edge k+S+2.
- Per-grant period is S+2 cycles. Back-to-back requesters lose no extra cycles.
- seed_ld in IDLE takes effect at the next edge and delays any pending grant by one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset release, req=4'b0001, steps=1 -> gnt=0001 for 2 cycles; valid pulse with data=0xB8; busy low afterwards.
- From reset, req=4'b1111 held, steps=1 -> grants in order 0,1,2,3,0; data sequence 0xB8, 0x5C, 0x2E, 0x17, 0xB3; each valid spaced 3 cycles apart.
- steps=0 vs steps=1 from reset -> identical timing and data 0xB8. steps=3 from reset -> data=0x2E with valid 3 cycles after grant.
- seed_ld=1 with seed_in=0x00 in IDLE, then req0 with steps=1 -> data=0xB8 (SEED substituted). seed_ld with seed_in=0x02 together with req1 -> seed loaded first, grant one cycle later, data=0x01.
- steps=15, 17 consecutive grants -> final data=0x01 (full period 255). No data word is ever 0x00.
- rst pulled low during RUN (req2, steps=8, 4 cycles in) -> gnt/valid/busy drop immediately with no valid pulse. After release, req2 gets data from SEED and requester 0 has priority again.

Source files
------------

// File: rtl/lfsr_grant_ctrl.sv
// Round-robin scheduler sharing one Galois LFSR among four requesters.
// Each grant advances the LFSR a programmable number of steps and then
// delivers the resulting word to the granted requester.
module lfsr_grant_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       steps,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
  output logic [3:0]       gnt,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] lfsr_next;
  logic [1:0]       win;
  logic             found;

  // Right-shift Galois step.
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

  // Round-robin search starting just after the last winner.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] idx;
      idx = last_q + 2'(i + 1);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (seed_ld) begin
          // A zero seed would lock the LFSR, so fall back to SEED.
          lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else if (found) begin
          gnt_d   = 4'b0001 << win;
          cnt_d   = (steps == 4'd0) ? 4'd1 : steps;
          last_d  = win;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        lfsr_d = lfsr_next;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = lfsr_next;
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      data_q  <= '0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign data  = data_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_lfsr_grant_ctrl.sv
// Directed bench for lfsr_grant_ctrl: table of single-grant vectors plus
// hand-written sequences for reseeding, full period and mid-run reset.
module tb_lfsr_grant_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] steps;
  logic       seed_ld;
  logic [7:0] seed_in;
  logic [3:0] gnt;
  logic       valid;
  logic [7:0] data;
  logic       busy;

  int n_total;
  int n_pass;

  lfsr_grant_ctrl #(
    .WIDTH(8),
    .TAPS (8'hB8),
    .SEED (8'h01)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .steps  (steps),
    .seed_ld(seed_ld),
    .seed_in(seed_in),
    .gnt    (gnt),
    .valid  (valid),
    .data   (data),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_first;
    logic [3:0] req;
    logic [3:0] steps;
    logic [3:0] gnt;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] model_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    seed_ld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_gnt", {28'd0, gnt}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_data", {24'd0, data}, 32'd0);
    rst = 1'b1;
  endtask

  // One full grant: request at a negedge, then follow the S+2 cycle schedule.
  task automatic grant_check(input logic [3:0] r, input logic [3:0] s,
                             input logic [3:0] exp_gnt, input logic [7:0] exp_data);
    int s_eff;
    int early;
    s_eff = (s == 4'd0) ? 1 : int'(s);
    early = 0;
    @(negedge clk);
    req   = r;
    steps = s;
    @(posedge clk);
    #1;
    chk("grant_gnt", {28'd0, gnt}, {28'd0, exp_gnt});
    chk("grant_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i < s_eff; i++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0 || gnt !== exp_gnt) early++;
    end
    if (s_eff > 1) chk("run_quiet", early, 0);
    @(posedge clk);
    #1;
    chk("done_valid", {31'd0, valid}, 32'd1);
    chk("done_data", {24'd0, data}, {24'd0, exp_data});
    chk("done_gnt", {28'd0, gnt}, {28'd0, exp_gnt});
    @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_gnt", {28'd0, gnt}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_data_held", {24'd0, data}, {24'd0, exp_data});
  endtask

  initial begin
    logic [7:0] m;
    int bad;
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b0;
    req     = 4'b0000;
    steps   = 4'd1;
    seed_ld = 1'b0;
    seed_in = 8'h00;

    vecs[0] = '{1'b1, 4'b0001, 4'd1, 4'b0001, 8'hB8};
    vecs[1] = '{1'b1, 4'b1111, 4'd1, 4'b0001, 8'hB8};
    vecs[2] = '{1'b0, 4'b1111, 4'd1, 4'b0010, 8'h5C};
    vecs[3] = '{1'b0, 4'b1111, 4'd1, 4'b0100, 8'h2E};
    vecs[4] = '{1'b0, 4'b1111, 4'd1, 4'b1000, 8'h17};
    vecs[5] = '{1'b0, 4'b1111, 4'd1, 4'b0001, 8'hB3};
    vecs[6] = '{1'b1, 4'b0001, 4'd0, 4'b0001, 8'hB8};
    vecs[7] = '{1'b1, 4'b0001, 4'd3, 4'b0001, 8'h2E};
    vecs[8] = '{1'b1, 4'b0100, 4'd1, 4'b0100, 8'hB8};
    vecs[9] = '{1'b0, 4'b0101, 4'd2, 4'b0001, 8'h2E};

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst_first) do_reset();
      grant_check(vecs[v].req, vecs[v].steps, vecs[v].gnt, vecs[v].data);
    end
    req = 4'b0000;

    // Zero seed is replaced by SEED (load 0x02 first so the substitution shows).
    do_reset();
    @(negedge clk);
    seed_ld = 1'b1;
    seed_in = 8'h02;
    @(negedge clk);
    seed_in = 8'h00;
    @(negedge clk);
    seed_ld = 1'b0;
    grant_check(4'b0001, 4'd1, 4'b0001, 8'hB8);
    req = 4'b0000;

    // seed_ld wins over a simultaneous request; grant follows one cycle later.
    do_reset();
    @(negedge clk);
    seed_ld = 1'b1;
    seed_in = 8'h02;
    req     = 4'b0010;
    steps   = 4'd1;
    @(posedge clk);
    #1;
    chk("seed_pri_gnt", {28'd0, gnt}, 32'd0);
    chk("seed_pri_busy", {31'd0, busy}, 32'd0);
    seed_ld = 1'b0;
    grant_check(4'b0010, 4'd1, 4'b0010, 8'h01);
    req = 4'b0000;

    // 17 grants of 15 steps walk the full 255-state period.
    do_reset();
    m   = 8'h01;
    bad = 0;
    for (int g = 0; g < 17; g++) begin
      for (int k = 0; k < 15; k++) m = model_step(m);
      grant_check(4'b0001, 4'd15, 4'b0001, m);
      if (data == 8'h00) bad++;
    end
    chk("period_final", {24'd0, data}, 32'h01);
    chk("never_zero", bad, 0);
    req = 4'b0000;

    // Asynchronous reset mid-run discards the grant.
    do_reset();
    @(negedge clk);
    req   = 4'b0100;
    steps = 4'd8;
    for (int c = 0; c < 5; c++) @(posedge clk);
    #2;
    chk("pre_rst_gnt", {28'd0, gnt}, 32'b0100);
    rst = 1'b0;
    #1;
    chk("async_gnt", {28'd0, gnt}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_valid", {31'd0, valid}, 32'd0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0) bad++;
    end
    chk("no_pulse_in_rst", bad, 0);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    grant_check(4'b0101, 4'd1, 4'b0001, 8'hB8);
    grant_check(4'b0100, 4'd1, 4'b0100, 8'h5C);
    req = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
